// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, datapath
// mux codes, ALU operations, opcode/funct constants and the decoded-instruction record.
package mc_ctrl_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_t;

  // ALU_NOP passes operand A through unchanged; lui relies on this.
  localparam logic [ALU_W-1:0] ALU_NOP  = 4'd0;
  localparam logic [ALU_W-1:0] ALU_ADD  = 4'd1;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'd2;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'd3;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'd4;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'd5;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'd6;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'd7;
  localparam logic [ALU_W-1:0] ALU_NOR  = 4'd8;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'd9;

  localparam logic [1:0] SRCA_RS    = 2'b00;
  localparam logic [1:0] SRCA_SHAMT = 2'b01;
  localparam logic [1:0] SRCA_LUI   = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b11;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  localparam logic [1:0] GPR_RD     = 2'b00;
  localparam logic [1:0] GPR_RT     = 2'b01;
  localparam logic [1:0] GPR_RA     = 2'b10;

  localparam logic [1:0] WD_ALU     = 2'b00;
  localparam logic [1:0] WD_MDR     = 2'b01;
  localparam logic [1:0] WD_PC      = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_JAL,
    CLS_JR,
    CLS_ILLEGAL
  } instr_cls_t;

  typedef struct packed {
    instr_cls_t       cls;
    logic [ALU_W-1:0] alu_op;
    logic [1:0]       src_a;
    logic [1:0]       src_b;
    logic             ext_op;
  } dec_t;

  function automatic logic is_alu(input instr_cls_t c);
    return (c == CLS_ALU_R) || (c == CLS_ALU_I);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath/memory bundle. Handshake: MemRead/MemWrite/IorD are held
// stable until the cycle mem_ready=1, which completes the access in that same cycle.
interface mc_ctrl_if #(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
);
  logic [5:0]         Op;
  logic [5:0]         Funct;
  logic               Zero;
  logic               mem_ready;
  logic               PCWrite;
  logic               IRWrite;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               RegWrite;
  logic               EXTOp;
  logic [ALUOP_W-1:0] ALUOp;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         NPCOp;
  logic [1:0]         GPRSel;
  logic [1:0]         WDSel;
  logic [2:0]         state;
  logic               illegal;
  logic               mem_err;
  logic [CNT_W-1:0]   instret;

  modport master (
    input  Op, Funct, Zero, mem_ready,
    output PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp,
           ALUOp, ALUSrcA, ALUSrcB, NPCOp, GPRSel, WDSel,
           state, illegal, mem_err, instret
  );

  modport slave (
    output Op, Funct, Zero, mem_ready,
    input  PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp,
           ALUOp, ALUSrcA, ALUSrcB, NPCOp, GPRSel, WDSel,
           state, illegal, mem_err, instret
  );
endinterface

// File: rtl/mc_decode.sv
// Pure combinational instruction decoder: Op/Funct -> instruction class plus the
// ALU operation, operand selects and immediate extension used in EX.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '{cls: CLS_ILLEGAL, alu_op: ALU_NOP, src_a: SRCA_RS,
            src_b: SRCB_RT, ext_op: 1'b0};
    case (op)
      OP_RTYPE: begin
        dec.cls = CLS_ALU_R;
        case (funct)
          FN_ADD, FN_ADDU: dec.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: dec.alu_op = ALU_SUB;
          FN_AND:          dec.alu_op = ALU_AND;
          FN_OR:           dec.alu_op = ALU_OR;
          FN_NOR:          dec.alu_op = ALU_NOR;
          FN_SLT:          dec.alu_op = ALU_SLT;
          FN_SLTU:         dec.alu_op = ALU_SLTU;
          FN_SLL: begin
            dec.alu_op = ALU_SLL;
            dec.src_a  = SRCA_SHAMT;
          end
          FN_SRL: begin
            dec.alu_op = ALU_SRL;
            dec.src_a  = SRCA_SHAMT;
          end
          FN_JR:           dec.cls = CLS_JR;
          default:         dec.cls = CLS_ILLEGAL;
        endcase
      end
      OP_ADDI: begin
        dec.cls    = CLS_ALU_I;
        dec.alu_op = ALU_ADD;
        dec.src_b  = SRCB_IMM;
        dec.ext_op = 1'b1;
      end
      OP_SLTI: begin
        dec.cls    = CLS_ALU_I;
        dec.alu_op = ALU_SLT;
        dec.src_b  = SRCB_IMM;
        dec.ext_op = 1'b1;
      end
      // ori zero-extends its immediate
      OP_ORI: begin
        dec.cls    = CLS_ALU_I;
        dec.alu_op = ALU_OR;
        dec.src_b  = SRCB_IMM;
      end
      OP_LUI: begin
        dec.cls    = CLS_ALU_I;
        dec.alu_op = ALU_NOP;
        dec.src_a  = SRCA_LUI;
        dec.src_b  = SRCB_IMM;
      end
      OP_LW, OP_SW: begin
        dec.cls    = (op == OP_LW) ? CLS_LW : CLS_SW;
        dec.alu_op = ALU_ADD;
        dec.src_b  = SRCB_IMM;
        dec.ext_op = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec.cls    = (op == OP_BEQ) ? CLS_BEQ : CLS_BNE;
        dec.alu_op = ALU_SUB;
      end
      OP_J:    dec.cls = CLS_J;
      OP_JAL:  dec.cls = CLS_JAL;
      default: dec.cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) over one shared memory port,
// with a memory-wait timeout and a retired-instruction counter.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.master bus
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT) + 1;

  state_t           state_q;
  state_t           state_d;
  logic [TMO_W-1:0] tmo_q;
  logic [CNT_W-1:0] instret_q;
  dec_t             dec;
  logic             waiting;
  logic             timeout;
  logic             retire;

  mc_decode u_decode (
    .op    (bus.Op),
    .funct (bus.Funct),
    .dec   (dec)
  );

  assign waiting = ((state_q == ST_IF) || (state_q == ST_MEM)) && !bus.mem_ready;
  assign timeout = waiting && (tmo_q == TMO_W'(MEM_TIMEOUT - 1));
  assign bus.instret = instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_IF: begin
        if (timeout)            state_d = ST_IF;
        else if (bus.mem_ready) state_d = ST_ID;
      end
      ST_ID: state_d = (dec.cls == CLS_ILLEGAL) ? ST_IF : ST_EX;
      ST_EX: begin
        if (is_alu(dec.cls)) begin
          state_d = ST_WB;
        end else if ((dec.cls == CLS_LW) || (dec.cls == CLS_SW)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_IF;
          retire  = 1'b1;
        end
      end
      ST_MEM: begin
        if (timeout) begin
          state_d = ST_IF;
        end else if (bus.mem_ready) begin
          if (dec.cls == CLS_LW) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_IF;
            retire  = 1'b1;
          end
        end
      end
      ST_WB: begin
        state_d = ST_IF;
        retire  = 1'b1;
      end
      default: state_d = ST_IF;
    endcase
  end

  // Wait counter restarts on every state change and after an abort that stays in IF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q     <= '0;
      instret_q <= '0;
    end else begin
      if (timeout || (state_d != state_q)) tmo_q <= '0;
      else if (waiting)                    tmo_q <= tmo_q + TMO_W'(1);
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Outputs are forced low while rst is high so a reset mid-access drops requests at once.
  always_comb begin
    bus.PCWrite  = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.RegWrite = 1'b0;
    bus.EXTOp    = 1'b0;
    bus.ALUOp    = '0;
    bus.ALUSrcA  = SRCA_RS;
    bus.ALUSrcB  = SRCB_RT;
    bus.NPCOp    = NPC_PC4;
    bus.GPRSel   = GPR_RD;
    bus.WDSel    = WD_ALU;
    bus.state    = state_q;
    bus.illegal  = 1'b0;
    bus.mem_err  = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IF: begin
          bus.MemRead = 1'b1;
          bus.mem_err = timeout;
          if (bus.mem_ready) begin
            bus.IRWrite = 1'b1;
            bus.PCWrite = 1'b1;
            bus.NPCOp   = NPC_PC4;
          end
        end
        ST_ID: bus.illegal = (dec.cls == CLS_ILLEGAL);
        ST_EX: begin
          bus.ALUOp   = ALUOP_W'(dec.alu_op);
          bus.ALUSrcA = dec.src_a;
          bus.ALUSrcB = dec.src_b;
          bus.EXTOp   = dec.ext_op;
          case (dec.cls)
            CLS_BEQ, CLS_BNE: begin
              bus.NPCOp   = NPC_BRANCH;
              bus.PCWrite = (dec.cls == CLS_BEQ) ? bus.Zero : !bus.Zero;
            end
            CLS_J: begin
              bus.PCWrite = 1'b1;
              bus.NPCOp   = NPC_JUMP;
            end
            // PC already holds the return address after the fetch increment
            CLS_JAL: begin
              bus.PCWrite  = 1'b1;
              bus.NPCOp    = NPC_JUMP;
              bus.RegWrite = 1'b1;
              bus.GPRSel   = GPR_RA;
              bus.WDSel    = WD_PC;
            end
            CLS_JR: begin
              bus.PCWrite = 1'b1;
              bus.NPCOp   = NPC_JR;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          bus.IorD     = 1'b1;
          bus.MemRead  = (dec.cls == CLS_LW);
          bus.MemWrite = (dec.cls == CLS_SW) && !timeout;
          bus.mem_err  = timeout;
        end
        ST_WB: begin
          bus.RegWrite = 1'b1;
          bus.GPRSel   = ((dec.cls == CLS_ALU_I) || (dec.cls == CLS_LW)) ? GPR_RT : GPR_RD;
          bus.WDSel    = (dec.cls == CLS_LW) ? WD_MDR : WD_ALU;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction cycle traces are generated from the instruction
// behaviour and compared cycle by cycle against the controller outputs.
module tb_mc_ctrl;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 32;
  localparam int ALUOP_W     = 4;
  localparam int NINS        = 25;

  localparam logic [3:0] K_R = 4'd0, K_I = 4'd1, K_LW = 4'd2, K_SW = 4'd3, K_BEQ = 4'd4,
                         K_BNE = 4'd5, K_J = 4'd6, K_JAL = 4'd7, K_JR = 4'd8, K_ILL = 4'd9;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] funct;
    logic [3:0] kind;
    logic [3:0] alu;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       ext;
  } ins_t;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, irw, iord, mrd, mwr, rw, ext;
    logic [3:0] alu;
    logic [1:0] sa, sb, npc, gsel, wsel;
    logic       ill, merr;
  } ov_t;

  localparam int OVW = $bits(ov_t);

  logic clk = 1'b0;
  logic rst = 1'b1;

  mc_ctrl_if #(.ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

  mc_ctrl #(.ALUOP_W(ALUOP_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [OVW-1:0]   exp_q[$];
  logic             rdy_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  logic [CNT_W-1:0] exp_instret = '0;

  // Instruction table: opcode, funct, kind, and the ALU fields expected in EX for ALU ops.
  function automatic ins_t ins(input int i);
    case (i)
      0:  return '{6'h00, 6'h20, K_R, 4'd1, 2'd0, 2'd0, 1'b0}; // add
      1:  return '{6'h00, 6'h21, K_R, 4'd1, 2'd0, 2'd0, 1'b0}; // addu
      2:  return '{6'h00, 6'h22, K_R, 4'd2, 2'd0, 2'd0, 1'b0}; // sub
      3:  return '{6'h00, 6'h23, K_R, 4'd2, 2'd0, 2'd0, 1'b0}; // subu
      4:  return '{6'h00, 6'h24, K_R, 4'd3, 2'd0, 2'd0, 1'b0}; // and
      5:  return '{6'h00, 6'h25, K_R, 4'd4, 2'd0, 2'd0, 1'b0}; // or
      6:  return '{6'h00, 6'h27, K_R, 4'd8, 2'd0, 2'd0, 1'b0}; // nor
      7:  return '{6'h00, 6'h2A, K_R, 4'd5, 2'd0, 2'd0, 1'b0}; // slt
      8:  return '{6'h00, 6'h2B, K_R, 4'd6, 2'd0, 2'd0, 1'b0}; // sltu
      9:  return '{6'h00, 6'h00, K_R, 4'd7, 2'd1, 2'd0, 1'b0}; // sll
      10: return '{6'h00, 6'h02, K_R, 4'd9, 2'd1, 2'd0, 1'b0}; // srl
      11: return '{6'h08, 6'h00, K_I, 4'd1, 2'd0, 2'd1, 1'b1}; // addi
      12: return '{6'h0D, 6'h00, K_I, 4'd4, 2'd0, 2'd1, 1'b0}; // ori
      13: return '{6'h0A, 6'h00, K_I, 4'd5, 2'd0, 2'd1, 1'b1}; // slti
      14: return '{6'h0F, 6'h00, K_I, 4'd0, 2'd2, 2'd1, 1'b0}; // lui
      15: return '{6'h23, 6'h00, K_LW, 4'd0, 2'd0, 2'd0, 1'b0};
      16: return '{6'h2B, 6'h00, K_SW, 4'd0, 2'd0, 2'd0, 1'b0};
      17: return '{6'h04, 6'h00, K_BEQ, 4'd0, 2'd0, 2'd0, 1'b0};
      18: return '{6'h05, 6'h00, K_BNE, 4'd0, 2'd0, 2'd0, 1'b0};
      19: return '{6'h02, 6'h00, K_J, 4'd0, 2'd0, 2'd0, 1'b0};
      20: return '{6'h03, 6'h00, K_JAL, 4'd0, 2'd0, 2'd0, 1'b0};
      21: return '{6'h00, 6'h08, K_JR, 4'd0, 2'd0, 2'd0, 1'b0};
      22: return '{6'h3F, 6'h00, K_ILL, 4'd0, 2'd0, 2'd0, 1'b0};
      23: return '{6'h00, 6'h3F, K_ILL, 4'd0, 2'd0, 2'd0, 1'b0};
      default: return '{6'h01, 6'h00, K_ILL, 4'd0, 2'd0, 2'd0, 1'b0};
    endcase
  endfunction

  function automatic ov_t blank(input logic [2:0] st);
    ov_t v;
    v    = '0;
    v.st = st;
    return v;
  endfunction

  function automatic ov_t actual();
    ov_t v;
    v.st = bus.state;     v.pcw = bus.PCWrite;  v.irw = bus.IRWrite;
    v.iord = bus.IorD;    v.mrd = bus.MemRead;  v.mwr = bus.MemWrite;
    v.rw = bus.RegWrite;  v.ext = bus.EXTOp;    v.alu = bus.ALUOp;
    v.sa = bus.ALUSrcA;   v.sb = bus.ALUSrcB;   v.npc = bus.NPCOp;
    v.gsel = bus.GPRSel;  v.wsel = bus.WDSel;   v.ill = bus.illegal;
    v.merr = bus.mem_err;
    return v;
  endfunction

  task automatic push(input ov_t v, input logic rdy);
    exp_q.push_back(v);
    rdy_q.push_back(rdy);
  endtask

  // Reference model: expected per-cycle outputs and mem_ready stimulus for one instruction.
  // A wait of MEM_TIMEOUT or more means the access never completes and is aborted.
  task automatic build_trace(input ins_t in, input logic zero, input int if_wait,
                             input int mem_wait, output bit ret);
    ov_t v;
    ret = 0;
    v = blank(3'd0);
    v.mrd = 1'b1;
    if (if_wait >= MEM_TIMEOUT) begin
      repeat (MEM_TIMEOUT - 1) push(v, 1'b0);
      v.merr = 1'b1;
      push(v, 1'b0);
      return;
    end
    repeat (if_wait) push(v, 1'b0);
    v.irw = 1'b1;
    v.pcw = 1'b1;
    push(v, 1'b1);

    v = blank(3'd1);
    v.ill = (in.kind == K_ILL);
    push(v, 1'($urandom));
    if (in.kind == K_ILL) return;

    v = blank(3'd2);
    case (in.kind)
      K_R, K_I: begin
        v.alu = in.alu; v.sa = in.sa; v.sb = in.sb; v.ext = in.ext;
      end
      K_LW, K_SW: begin
        v.alu = 4'd1; v.sb = 2'd1; v.ext = 1'b1;
      end
      K_BEQ, K_BNE: begin
        v.alu = 4'd2;
        v.npc = 2'd1;
        v.pcw = (in.kind == K_BEQ) ? zero : !zero;
      end
      K_J:   begin v.pcw = 1'b1; v.npc = 2'd2; end
      K_JAL: begin v.pcw = 1'b1; v.npc = 2'd2; v.rw = 1'b1; v.gsel = 2'd2; v.wsel = 2'd2; end
      K_JR:  begin v.pcw = 1'b1; v.npc = 2'd3; end
      default: ;
    endcase
    push(v, 1'($urandom));
    if (in.kind >= K_BEQ) begin
      ret = 1;
      return;
    end

    if (in.kind == K_LW || in.kind == K_SW) begin
      v = blank(3'd3);
      v.iord = 1'b1;
      v.mrd = (in.kind == K_LW);
      v.mwr = (in.kind == K_SW);
      if (mem_wait >= MEM_TIMEOUT) begin
        repeat (MEM_TIMEOUT - 1) push(v, 1'b0);
        v.mwr  = 1'b0;
        v.merr = 1'b1;
        push(v, 1'b0);
        return;
      end
      repeat (mem_wait) push(v, 1'b0);
      push(v, 1'b1);
      if (in.kind == K_SW) begin
        ret = 1;
        return;
      end
    end

    v = blank(3'd4);
    v.rw = 1'b1;
    v.gsel = (in.kind == K_I || in.kind == K_LW) ? 2'd1 : 2'd0;
    v.wsel = (in.kind == K_LW) ? 2'd1 : 2'd0;
    push(v, 1'($urandom));
    ret = 1;
  endtask

  // Entered and left just after a rising edge with the controller in IF.
  task automatic run_instr(input string name, input int idx, input logic zero,
                           input int if_wait, input int mem_wait);
    ins_t in;
    ov_t  e, a;
    bit   ret;
    int   cyc;
    in = ins(idx);
    bus.Op    = in.op;
    bus.Funct = (in.op == 6'h00) ? in.funct : 6'($urandom);
    bus.Zero  = zero;
    build_trace(in, zero, if_wait, mem_wait, ret);
    cyc = 0;
    while (exp_q.size() > 0) begin
      bus.mem_ready = rdy_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      a = actual();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s cyc%0d: outputs got %h expected %h", name, cyc, a, e);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (ret) exp_instret = exp_instret + CNT_W'(1);
    n_tests++;
    if (bus.instret !== exp_instret) begin
      n_fail++;
      $display("FAIL %s instret: got %0d expected %0d", name, bus.instret, exp_instret);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Op = 6'h2B; bus.Funct = 6'h00; bus.Zero = 1'b0; bus.mem_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (actual() !== ov_t'('0)) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", actual());
    end
    n_tests++;
    if (bus.instret !== '0) begin
      n_fail++;
      $display("FAIL reset_instret: got %0d expected 0", bus.instret);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_instret = '0;
  endtask

  task automatic test_add();
    run_instr("add", 0, 1'b0, 0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait3", 15, 1'b0, 0, 3);
    run_instr("sw_nowait", 16, 1'b0, 0, 0);
  endtask

  task automatic test_branches();
    run_instr("bne_nz", 18, 1'b0, 0, 0);
    run_instr("bne_z", 18, 1'b1, 0, 0);
    run_instr("beq_z", 17, 1'b1, 1, 0);
    run_instr("beq_nz", 17, 1'b0, 0, 0);
  endtask

  task automatic test_jumps();
    run_instr("j", 19, 1'b0, 0, 0);
    run_instr("jal", 20, 1'b0, 0, 0);
    run_instr("jr", 21, 1'b0, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_op3f", 22, 1'b0, 0, 0);
    run_instr("illegal_funct", 23, 1'b0, 0, 0);
    run_instr("illegal_op01", 24, 1'b0, 2, 0);
  endtask

  task automatic test_timeout();
    run_instr("if_tmo", 0, 1'b0, MEM_TIMEOUT, 0);
    run_instr("if_tmo_again", 0, 1'b0, MEM_TIMEOUT, 0);
    run_instr("if_max_wait", 0, 1'b0, MEM_TIMEOUT - 1, 0);
    run_instr("sw_tmo", 16, 1'b0, 0, MEM_TIMEOUT);
    run_instr("lw_tmo", 15, 1'b0, 0, MEM_TIMEOUT);
    run_instr("sw_max_wait", 16, 1'b0, 0, MEM_TIMEOUT - 1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 120; n++) begin
      int idx, iw, mw;
      idx = $urandom_range(0, NINS - 1);
      iw  = ($urandom_range(0, 9) == 0) ? $urandom_range(4, MEM_TIMEOUT) : $urandom_range(0, 2);
      mw  = ($urandom_range(0, 9) == 0) ? $urandom_range(4, MEM_TIMEOUT) : $urandom_range(0, 2);
      run_instr("random", idx, 1'($urandom), iw, mw);
    end
  endtask

  task automatic test_rst_mid_sw();
    ov_t e;
    bus.Op = 6'h2B; bus.Funct = 6'h00; bus.Zero = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    e = blank(3'd3);
    e.iord = 1'b1;
    e.mwr  = 1'b1;
    n_tests++;
    if (actual() !== e) begin
      n_fail++;
      $display("FAIL rst_mid_sw_pre: got %h expected %h", actual(), e);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (actual() !== ov_t'('0)) begin
      n_fail++;
      $display("FAIL rst_mid_sw_outputs: got %h expected 0", actual());
    end
    n_tests++;
    if (bus.instret !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_sw_instret: got %0d expected 0", bus.instret);
    end
    exp_instret = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr("add_after_rst", 0, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branches();
    test_jumps();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_rst_mid_sw();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
